// File: rtl/rpn_pkg.sv
// Shared types for the RPN command sequencer: command and ALU opcodes, error codes,
// FSM states and the command-to-ALU opcode map.
package rpn_pkg;

  typedef enum logic [3:0] {
    CMD_PUSH = 4'd0,
    CMD_POP  = 4'd1,
    CMD_ADD  = 4'd2,
    CMD_SUB  = 4'd3,
    CMD_MUL  = 4'd4,
    CMD_SLL  = 4'd5,
    CMD_SRL  = 4'd6,
    CMD_SLT  = 4'd7,
    CMD_AND  = 4'd8,
    CMD_OR   = 4'd9,
    CMD_NOR  = 4'd10,
    CMD_XOR  = 4'd11,
    CMD_SWAP = 4'd12
  } cmd_e;

  typedef enum logic [3:0] {
    ALU_AND = 4'd0,
    ALU_OR  = 4'd1,
    ALU_NOR = 4'd2,
    ALU_XOR = 4'd3,
    ALU_ADD = 4'd4,
    ALU_SUB = 4'd5,
    ALU_MUL = 4'd7,
    ALU_SLL = 4'd8,
    ALU_SRL = 4'd9,
    ALU_SLT = 4'd12
  } alu_op_e;

  typedef enum logic [1:0] {
    ERR_OK      = 2'b00,
    ERR_UNDER   = 2'b01,
    ERR_OVER    = 2'b10,
    ERR_ILLEGAL = 2'b11
  } err_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_POP1  = 3'd2,
    ST_POP2  = 3'd3,
    ST_PUSH1 = 3'd4,
    ST_PUSH2 = 3'd5,
    ST_RESP  = 3'd6
  } state_e;

  localparam logic [3:0] CMD_LAST    = 4'd12;
  localparam logic [7:0] ERR_CNT_MAX = 8'hFF;

  // Non-ALU commands map to AND so the opcode bus rests at its reset value.
  function automatic alu_op_e cmd_to_alu(input logic [3:0] op);
    case (op)
      CMD_ADD: return ALU_ADD;
      CMD_SUB: return ALU_SUB;
      CMD_MUL: return ALU_MUL;
      CMD_SLL: return ALU_SLL;
      CMD_SRL: return ALU_SRL;
      CMD_SLT: return ALU_SLT;
      CMD_OR:  return ALU_OR;
      CMD_NOR: return ALU_NOR;
      CMD_XOR: return ALU_XOR;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic logic is_binary(input logic [3:0] op);
    return (op >= 4'd2) && (op <= 4'd11);
  endfunction

endpackage

// File: rtl/rpn_seq_if.sv
// Command/response channel between the key-decode front end and the RPN sequencer.
interface rpn_seq_if #(parameter int W = 32);
  import rpn_pkg::*;

  // A command transfers on a rising edge where cmd_valid && cmd_ready; the master
  // holds op/val stable while cmd_valid is high and unaccepted. rsp_valid is a
  // single-cycle pulse with no backpressure; rsp_err is meaningful only with it.
  logic         cmd_valid;
  logic         cmd_ready;
  logic [3:0]   cmd_op;
  logic [W-1:0] cmd_val;
  logic         rsp_valid;
  err_e         rsp_err;

  modport master (output cmd_valid, cmd_op, cmd_val, input cmd_ready, rsp_valid, rsp_err);
  modport slave  (input cmd_valid, cmd_op, cmd_val, output cmd_ready, rsp_valid, rsp_err);
endinterface

// File: rtl/rpn_seq.sv
// Checked micro-sequencer: takes one calculator command, validates stack depth,
// strobes pops/pushes and drives the ALU, then reports a one-cycle response.
module rpn_seq
  import rpn_pkg::*;
#(
  parameter int W     = 32,
  parameter int DEPTH = 64,
  parameter int DW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  rpn_seq_if.slave      cmd,
  output logic          stk_push,
  output logic          stk_pop,
  output logic [W-1:0]  stk_din,
  input  logic [W-1:0]  stk_top,
  input  logic [W-1:0]  stk_next,
  input  logic [DW-1:0] stk_depth,
  input  logic          stk_full,
  output alu_op_e       alu_op,
  output logic [W-1:0]  alu_a,
  output logic [W-1:0]  alu_b,
  output logic [4:0]    alu_shamt,
  input  logic [W-1:0]  alu_lo,
  output logic          busy,
  output logic [7:0]    err_cnt,
  output state_e        dbg_state
);

  state_e       r_state, w_state_nxt;
  logic [3:0]   r_op;
  logic [W-1:0] r_val;
  err_e         r_err, w_err;
  alu_op_e      r_alu_op;
  logic [W-1:0] r_alu_a, r_alu_b;
  logic [4:0]   r_shamt;
  logic [7:0]   r_err_cnt;

  always_comb begin
    w_err = ERR_OK;
    if (r_op > CMD_LAST)                                         w_err = ERR_ILLEGAL;
    else if (r_op == CMD_PUSH && stk_full)                       w_err = ERR_OVER;
    else if (r_op == CMD_POP && stk_depth == '0)                 w_err = ERR_UNDER;
    else if ((is_binary(r_op) || r_op == CMD_SWAP) && stk_depth < DW'(2)) w_err = ERR_UNDER;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (cmd.cmd_valid) w_state_nxt = ST_CHECK;
      ST_CHECK: begin
        if (w_err != ERR_OK)       w_state_nxt = ST_RESP;
        else if (r_op == CMD_PUSH) w_state_nxt = ST_PUSH1;
        else                       w_state_nxt = ST_POP1;
      end
      ST_POP1:  w_state_nxt = (r_op == CMD_POP) ? ST_RESP : ST_POP2;
      ST_POP2:  w_state_nxt = ST_PUSH1;
      ST_PUSH1: w_state_nxt = (r_op == CMD_SWAP) ? ST_PUSH2 : ST_RESP;
      ST_PUSH2: w_state_nxt = ST_RESP;
      ST_RESP:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_op      <= '0;
      r_val     <= '0;
      r_err     <= ERR_OK;
      r_alu_op  <= ALU_AND;
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_shamt   <= '0;
      r_err_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_IDLE && cmd.cmd_valid) begin
        r_op  <= cmd.cmd_op;
        r_val <= cmd.cmd_val;
      end
      if (r_state == ST_CHECK) begin
        r_err <= w_err;
        // Operands are only captured for commands that will actually run.
        if (w_err == ERR_OK) begin
          r_alu_op <= cmd_to_alu(r_op);
          r_alu_a  <= stk_top;
          r_alu_b  <= stk_next;
          r_shamt  <= stk_top[4:0];
        end
      end
      if (r_state == ST_RESP && r_err != ERR_OK && r_err_cnt != ERR_CNT_MAX)
        r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  // Strobes and the response are gated by rst so they drop in the reset cycle itself.
  always_comb begin
    stk_push      = 1'b0;
    stk_pop       = 1'b0;
    stk_din       = '0;
    cmd.rsp_valid = 1'b0;
    cmd.rsp_err   = ERR_OK;
    if (!rst) begin
      case (r_state)
        ST_POP1, ST_POP2: stk_pop = 1'b1;
        ST_PUSH1: begin
          stk_push = 1'b1;
          if (r_op == CMD_PUSH)      stk_din = r_val;
          else if (r_op == CMD_SWAP) stk_din = r_alu_a;
          else                       stk_din = alu_lo;
        end
        ST_PUSH2: begin
          stk_push = 1'b1;
          stk_din  = r_alu_b;
        end
        ST_RESP: begin
          cmd.rsp_valid = 1'b1;
          cmd.rsp_err   = r_err;
        end
        default: ;
      endcase
    end
  end

  assign cmd.cmd_ready = (r_state == ST_IDLE);
  assign busy          = (r_state != ST_IDLE);
  assign alu_op        = r_alu_op;
  assign alu_a         = r_alu_a;
  assign alu_b         = r_alu_b;
  assign alu_shamt     = r_shamt;
  assign err_cnt       = r_err_cnt;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_rpn_seq.sv
// Bench for rpn_seq: behavioural stack and ALU around the DUT, queue-based
// reference model of the calculator, directed and random command streams.
module tb_rpn_seq;
  import rpn_pkg::*;

  localparam int W     = 32;
  localparam int DEPTH = 64;
  localparam int DW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          stk_push, stk_pop, stk_full;
  logic [W-1:0]  stk_din, stk_top, stk_next, alu_a, alu_b, alu_lo;
  logic [DW-1:0] stk_depth;
  alu_op_e       alu_op;
  logic [4:0]    alu_shamt;
  logic          busy;
  logic [7:0]    err_cnt;
  state_e        dbg_state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rpn_seq_if #(.W(W)) cif ();

  rpn_seq #(.W(W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .cmd(cif),
    .stk_push(stk_push), .stk_pop(stk_pop), .stk_din(stk_din),
    .stk_top(stk_top), .stk_next(stk_next), .stk_depth(stk_depth), .stk_full(stk_full),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_shamt(alu_shamt), .alu_lo(alu_lo),
    .busy(busy), .err_cnt(err_cnt), .dbg_state(dbg_state)
  );

  // Stack and ALU standing in for the real datapath
  logic [W-1:0] mem [DEPTH];
  logic [6:0]   sdepth;
  logic [5:0]   top_i, nxt_i;
  assign top_i     = 6'(sdepth - 7'd1);
  assign nxt_i     = 6'(sdepth - 7'd2);
  assign stk_top   = (sdepth != 7'd0) ? mem[top_i] : '0;
  assign stk_next  = (sdepth > 7'd1) ? mem[nxt_i] : '0;
  assign stk_depth = sdepth;
  assign stk_full  = (sdepth == 7'd64);

  always @(posedge clk) begin
    if (rst) sdepth <= 7'd0;
    else if (stk_pop && sdepth != 7'd0) sdepth <= sdepth - 7'd1;
    else if (stk_push && sdepth != 7'd64) begin
      mem[sdepth[5:0]] <= stk_din;
      sdepth <= sdepth + 7'd1;
    end
  end

  always_comb begin
    alu_lo = '0;
    case (alu_op)
      ALU_ADD: alu_lo = alu_b + alu_a;
      ALU_SUB: alu_lo = alu_b - alu_a;
      ALU_MUL: alu_lo = alu_b * alu_a;
      ALU_SLL: alu_lo = alu_b << alu_shamt;
      ALU_SRL: alu_lo = alu_b >> alu_shamt;
      ALU_SLT: alu_lo = (alu_b < alu_a) ? 32'd1 : 32'd0;
      ALU_AND: alu_lo = alu_b & alu_a;
      ALU_OR:  alu_lo = alu_b | alu_a;
      ALU_NOR: alu_lo = ~(alu_b | alu_a);
      ALU_XOR: alu_lo = alu_b ^ alu_a;
      default: alu_lo = '0;
    endcase
  end

  // Reference model: the calculator stack as a queue, top at the back
  logic [W-1:0] ref_q[$];
  int           ref_errs = 0;

  task automatic chk(input string tag, input string what, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s %s observed=%0h expected=%0h", tag, what, obs, exp);
    end
  endtask

  task automatic model(input logic [3:0] op, input logic [W-1:0] val,
                       output logic [1:0] e, output int lat, output logic [15:0] seq);
    logic [W-1:0] t, n, r;
    logic [63:0]  p;
    int           sz;
    sz  = ref_q.size();
    e   = 2'd0;
    seq = 16'd0;
    lat = 0;
    r   = '0;
    if (op > 4'd12) e = 2'd3;
    else if (op == 4'd0) begin if (sz == DEPTH) e = 2'd2; end
    else if (op == 4'd1) begin if (sz < 1) e = 2'd1; end
    else if (sz < 2) e = 2'd1;
    if (e != 2'd0) begin
      lat = 2;
      if (ref_errs < 255) ref_errs++;
      return;
    end
    case (op)
      4'd0: begin ref_q.push_back(val); lat = 3; seq = 16'h0002; end
      4'd1: begin void'(ref_q.pop_back()); lat = 3; seq = 16'h0001; end
      4'd12: begin
        t = ref_q.pop_back();
        n = ref_q.pop_back();
        ref_q.push_back(t);
        ref_q.push_back(n);
        lat = 6; seq = 16'h005A;
      end
      default: begin
        t = ref_q.pop_back();
        n = ref_q.pop_back();
        p = 64'(n) * 64'(t);
        case (op)
          4'd2:  r = n + t;
          4'd3:  r = n - t;
          4'd4:  r = p[31:0];
          4'd5:  r = n << t[4:0];
          4'd6:  r = n >> t[4:0];
          4'd7:  r = (n < t) ? 32'd1 : 32'd0;
          4'd8:  r = n & t;
          4'd9:  r = n | t;
          4'd10: r = ~(n | t);
          default: r = n ^ t;
        endcase
        ref_q.push_back(r);
        lat = 5; seq = 16'h0016;
      end
    endcase
  endtask

  task automatic check_stack(input string tag);
    chk(tag, "depth", 64'(stk_depth), 64'(ref_q.size()));
    chk(tag, "err_cnt", 64'(err_cnt), 64'(ref_errs));
    if (ref_q.size() >= 1) chk(tag, "top", 64'(stk_top), 64'(ref_q[ref_q.size()-1]));
    if (ref_q.size() >= 2) chk(tag, "next", 64'(stk_next), 64'(ref_q[ref_q.size()-2]));
  endtask

  // Issue one command, measure latency/strobes/response and compare with the model.
  task automatic run_cmd(input logic [3:0] op, input logic [W-1:0] val, input string tag, input bit hold);
    logic [1:0]  e_exp, got_err;
    int          lat_exp, cyc, rdy_busy;
    logic [15:0] seq_exp, seq;
    bit          both;
    model(op, val, e_exp, lat_exp, seq_exp);
    @(negedge clk);
    cyc = 0;
    while (!cif.cmd_ready && cyc < 20) begin @(negedge clk); cyc++; end
    chk(tag, "ready_wait", 64'(cyc < 20), 64'd1);
    cif.cmd_valid = 1'b1;
    cif.cmd_op    = op;
    cif.cmd_val   = val;
    @(posedge clk);
    #1;
    if (!hold) cif.cmd_valid = 1'b0;
    cif.cmd_op  = 4'($urandom_range(0, 15));
    cif.cmd_val = $urandom;
    seq = 16'd0; both = 1'b0; rdy_busy = 0;
    @(negedge clk);
    cyc = 1;
    while (!cif.rsp_valid && cyc < 20) begin
      if (stk_pop || stk_push) seq = {seq[13:0], stk_push, stk_pop};
      if (stk_pop && stk_push) both = 1'b1;
      if (cif.cmd_ready) rdy_busy++;
      @(negedge clk);
      cyc++;
    end
    got_err = cif.rsp_err;
    cif.cmd_valid = 1'b0;
    chk(tag, "latency", 64'(cyc), 64'(lat_exp));
    chk(tag, "rsp_err", 64'(got_err), 64'(e_exp));
    chk(tag, "strobe_seq", 64'(seq), 64'(seq_exp));
    chk(tag, "strobe_overlap", 64'(both), 64'd0);
    chk(tag, "ready_while_busy", 64'(rdy_busy), 64'd0);
    @(negedge clk);
    chk(tag, "rsp_pulse_width", 64'(cif.rsp_valid), 64'd0);
    check_stack(tag);
  endtask

  task automatic drain(input string tag);
    while (ref_q.size() > 0) run_cmd(4'd1, '0, tag, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] rop;
    int         cyc, rsp_seen;

    // Reset state
    rst = 1'b1;
    cif.cmd_valid = 1'b0;
    cif.cmd_op    = 4'd0;
    cif.cmd_val   = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset", "cmd_ready", 64'(cif.cmd_ready), 64'd1);
    chk("reset", "rsp_valid", 64'(cif.rsp_valid), 64'd0);
    chk("reset", "rsp_err", 64'(cif.rsp_err), 64'd0);
    chk("reset", "stk_push", 64'(stk_push), 64'd0);
    chk("reset", "stk_pop", 64'(stk_pop), 64'd0);
    chk("reset", "stk_din", 64'(stk_din), 64'd0);
    chk("reset", "alu_op", 64'(alu_op), 64'(ALU_AND));
    chk("reset", "alu_a", 64'(alu_a), 64'd0);
    chk("reset", "alu_b", 64'(alu_b), 64'd0);
    chk("reset", "alu_shamt", 64'(alu_shamt), 64'd0);
    chk("reset", "busy", 64'(busy), 64'd0);
    chk("reset", "err_cnt", 64'(err_cnt), 64'd0);
    chk("reset", "state", 64'(dbg_state), 64'(ST_IDLE));

    // Directed arithmetic
    run_cmd(4'd0, 32'd5, "push5", 1'b0);
    run_cmd(4'd0, 32'd3, "push3", 1'b0);
    run_cmd(4'd3, '0, "sub", 1'b0);
    chk("sub", "top_is_2", 64'(stk_top), 64'd2);
    drain("drain1");
    run_cmd(4'd0, 32'd5, "push5b", 1'b0);
    run_cmd(4'd0, 32'd3, "push3b", 1'b0);
    run_cmd(4'd5, '0, "sll", 1'b0);
    chk("sll", "top_is_40", 64'(stk_top), 64'd40);
    chk("sll", "alu_shamt_held", 64'(alu_shamt), 64'd3);
    drain("drain2");
    run_cmd(4'd0, 32'd9, "push9", 1'b0);
    run_cmd(4'd0, 32'd7, "push7", 1'b0);
    run_cmd(4'd12, '0, "swap", 1'b0);
    chk("swap", "top_is_9", 64'(stk_top), 64'd9);
    chk("swap", "next_is_7", 64'(stk_next), 64'd7);

    // Underflow cases
    drain("drain3");
    run_cmd(4'd1, '0, "pop_empty", 1'b0);
    run_cmd(4'd0, 32'd11, "push11", 1'b0);
    run_cmd(4'd2, '0, "add_depth1", 1'b0);
    chk("underflow", "err_cnt_is_2", 64'(err_cnt), 64'd2);

    // Overflow and illegal opcodes
    drain("drain4");
    for (int i = 0; i < DEPTH; i++) run_cmd(4'd0, $urandom, "fill", 1'b0);
    chk("fill", "stk_full", 64'(stk_full), 64'd1);
    run_cmd(4'd0, 32'd1, "push_full", 1'b0);
    run_cmd(4'd14, '0, "illegal14", 1'b0);
    run_cmd(4'd13, '0, "illegal13", 1'b0);
    run_cmd(4'd15, '0, "illegal15", 1'b0);
    run_cmd(4'd11, '0, "xor_full", 1'b0);

    // Command valid held high through a busy period
    drain("drain5");
    run_cmd(4'd0, 32'h77, "hold_push", 1'b1);
    run_cmd(4'd0, 32'h12, "hold_push2", 1'b1);
    run_cmd(4'd4, '0, "hold_mul", 1'b1);

    // Random stream
    for (int i = 0; i < 300; i++) begin
      rop = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) rop = 4'd0;
      if ($urandom_range(0, 1) == 0)
        run_cmd(rop, 32'($urandom_range(0, 40)), "rand", 1'b0);
      else
        run_cmd(rop, $urandom, "rand", 1'b0);
    end

    // Reset in the middle of an ADD
    drain("drain6");
    run_cmd(4'd0, 32'd20, "pre_rst_a", 1'b0);
    run_cmd(4'd0, 32'd22, "pre_rst_b", 1'b0);
    @(negedge clk);
    cif.cmd_valid = 1'b1;
    cif.cmd_op    = 4'd2;
    cif.cmd_val   = '0;
    @(posedge clk);
    #1;
    cif.cmd_valid = 1'b0;
    @(negedge clk);
    cyc = 0;
    while (dbg_state != ST_POP2 && cyc < 20) begin @(negedge clk); cyc++; end
    chk("midrst", "reach_pop2", 64'(cyc < 20), 64'd1);
    rst = 1'b1;
    #1;
    chk("midrst", "pop_dropped", 64'(stk_pop), 64'd0);
    chk("midrst", "no_rsp", 64'(cif.rsp_valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    ref_q.delete();
    ref_errs = 0;
    chk("midrst", "state_idle", 64'(dbg_state), 64'(ST_IDLE));
    chk("midrst", "cmd_ready", 64'(cif.cmd_ready), 64'd1);
    rsp_seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (cif.rsp_valid) rsp_seen++;
      @(negedge clk);
    end
    chk("midrst", "rsp_after_reset", 64'(rsp_seen), 64'd0);
    check_stack("midrst");
    run_cmd(4'd0, 32'd4, "post_rst_push", 1'b0);
    run_cmd(4'd1, '0, "post_rst_pop", 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rpn_seq.md
Name: rpn_seq

Overview:
- Command-driven micro-sequencer for the RPN stack/register file and ALU datapath.
- Accepts one calculator command at a time over a valid/ready handshake and checks the stack for underflow and overflow.
- Issues single-cycle pop/push strobes and drives ALU operands and opcode, then returns a one-cycle response with an error code.
- Sits between the key-decode front end and the stack/ALU, replacing ad-hoc per-key sequencing with one checked FSM.

Parameters:
- W, 32, data width of stack entries, ALU operands and cmd_val.
- DEPTH, 64, stack capacity; DW = $clog2(DEPTH)+1 is the width of stk_depth.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high only in IDLE
- cmd_op  in  4  opcode (rpn_pkg::cmd_e)
- cmd_val  in  W  push operand; ignored for other ops
- rsp_valid  out  1  one-cycle completion pulse
- rsp_err  out  2  00 ok, 01 underflow, 10 overflow, 11 illegal op; valid with rsp_valid
- stk_push  out  1  push strobe; stack writes stk_din on this edge
- stk_pop  out  1  pop strobe
- stk_din  out  W  push data
- stk_top  in  W  current top entry
- stk_next  in  W  entry below top
- stk_depth  in  DW  entry count
- stk_full  in  1  depth == DEPTH
- alu_op  out  4  ALU opcode (rpn_pkg::alu_op_e)
- alu_a  out  W  captured top
- alu_b  out  W  captured next
- alu_shamt  out  5  captured top[4:0]
- alu_lo  in  W  ALU low result (combinational)
- busy  out  1  state != IDLE
- err_cnt  out  8  saturating count of error responses

Behaviour:
- Reset values: state IDLE; cmd_ready 1; rsp_valid 0; rsp_err 00; stk_push 0; stk_pop 0; stk_din 0; alu_op AND; alu_a 0; alu_b 0; alu_shamt 0; busy 0; err_cnt 0.
- Reset mid-command: the FSM returns to IDLE, no response is issued, and the strobes drop in the same cycle. The stack is reset by its own rst.
- States: IDLE, CHECK, POP1, POP2, PUSH1, PUSH2, RESP.
- IDLE:
  - cmd_valid && cmd_ready registers op and val and moves to CHECK.
- CHECK:
  - Decides the error code.
  - PUSH with stk_full gives overflow.
  - POP with depth < 1 gives underflow.
  - Binary ops and SWAP with depth < 2 give underflow.
  - An opcode outside cmd_e gives illegal.
  - On error: go to RESP; the stack is not touched.
  - Otherwise, capture alu_a = stk_top, alu_b = stk_next, alu_shamt = stk_top[4:0], and alu_op from the package map.
  - Next state: PUSH goes to PUSH1; all other ops go to POP1.
- POP1:
  - stk_pop = 1.
  - Next state: POP goes to RESP; others go to POP2.
- POP2:
  - stk_pop = 1, then PUSH1.
- PUSH1:
  - stk_push = 1.
  - stk_din is cmd_val for PUSH, alu_a for SWAP, and alu_lo for binary ops.
  - Next state: SWAP goes to PUSH2; others go to RESP.
- PUSH2:
  - stk_push = 1, stk_din = alu_b, then RESP.
- RESP:
  - rsp_valid = 1 and rsp_err is driven, then IDLE.
  - err_cnt increments if rsp_err != 0 and saturates at 255.
  - There is no response backpressure.
- Latency in cycles from the handshake edge to rsp_valid high:
  - PUSH: 3
  - POP: 3
  - binary ops: 5
  - SWAP: 6
  - any error: 2
- Strobes:
  - stk_push and stk_pop are never high in the same cycle.
  - Each is high for exactly one cycle per POP/PUSH state.
- Arithmetic, with t = top and n = next at CHECK:
  - ADD: n+t
  - SUB: n−t
  - MUL: low W bits of unsigned n*t
  - SLL: n<<t[4:0]
  - SRL: n>>t[4:0] (logical)
  - SLT: 1 if n<t unsigned, else 0
  - AND, OR, NOR, XOR: bitwise
  - All results wrap at W bits.
- Captured operands hold stable from CHECK until the next CHECK.
- cmd_op and cmd_val are ignored while busy.

Decomposition:
- rpn_pkg holds:
  - cmd_e: PUSH=0, POP=1, ADD=2, SUB=3, MUL=4, SLL=5, SRL=6, SLT=7, AND=8, OR=9, NOR=10, XOR=11, SWAP=12; 13–15 are illegal.
  - alu_op_e: AND=0, OR=1, NOR=2, XOR=3, ADD=4, SUB=5, MUL=7, SLL=8, SRL=9, SLT=12.
  - err_e.
  - state_e.
  - A function mapping cmd_e to alu_op_e.
- No sub-module is needed. The bench instantiates rpn_seq with the existing stack and alu.

Test Plan:
- Reset, then PUSH 5, PUSH 3 → two responses with err 00 at +3 cycles each; depth 2; top 3, next 5.
- From [top 3, next 5]: SUB → rsp at +5 cycles; pop pulses in two consecutive cycles, then one push; depth 1; top 2. Repeat from the same stack with SLL → top 40 (5<<3).
- From [top 7, next 9]: SWAP → top 9, next 7 after +6 cycles; depth unchanged.
- Empty stack: POP → underflow at +2 with no strobes. ADD with depth 1 → underflow, stack unchanged. err_cnt = 2.
- Fill to DEPTH with PUSH, then PUSH 1 → overflow, no push strobe. Opcode 14 → illegal.
- Assert rst during POP2 of an ADD → no rsp_valid; state IDLE and cmd_ready 1 on the next cycle. Hold cmd_valid while busy → only one command accepted.
